sram_port_arbiter: RTL



---
 rtl/sram_arb_pkg.sv | 20 ++
 rtl/sram_port_arbiter_tag_pipe.sv | 33 +++
 rtl/sram_port_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default constants for the SRAM port arbiter.
// The optional starvation guard is enabled with SRAM_ARB_STARVE_GUARD_EN.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        S_ARB_IDLE = 2'd0,
        S_ARB_P0   = 2'd1,
        S_ARB_P1   = 2'd2,
        S_ARB_TURN = 2'd3
    } sram_arb_state_t;

    typedef logic arb_port_t;

    localparam arb_port_t PORT0 = 1'b0;
    localparam arb_port_t PORT1 = 1'b1;

    localparam int unsigned DEF_READ_LATENCY = 2;
    localparam int unsigned DEF_MAX_WAIT     = 15;

endpackage

// File: rtl/sram_port_arbiter_tag_pipe.sv
// {valid, port} shift register that steers each read return back to the
// port that issued it, DEPTH edges after acceptance.
module read_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_READ_LATENCY + 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  arb_port_t port,
    output logic      rvalid0,
    output logic      rvalid1
);

    logic [DEPTH-1:0] tag_valid;
    logic [DEPTH-1:0] tag_port;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_valid <= '0;
            tag_port  <= '0;
        end else begin
            tag_valid <= {tag_valid[DEPTH-2:0], push};
            tag_port  <= {tag_port[DEPTH-2:0], port};
        end
    end

    // Gated by reset so nothing leaks out while reset is asserted.
    assign rvalid0 = rst_n && tag_valid[DEPTH-1] && (tag_port[DEPTH-1] == PORT0);
    assign rvalid1 = rst_n && tag_valid[DEPTH-1] && (tag_port[DEPTH-1] == PORT1);

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of SRAM_Controller: port 0 has priority, reads are
// tagged for return. Define SRAM_ARB_STARVE_GUARD_EN to build the port-1 starvation guard.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = DEF_READ_LATENCY
`ifdef SRAM_ARB_STARVE_GUARD_EN
    ,
    parameter int MAX_WAIT     = DEF_MAX_WAIT
`endif
) (
    input  logic              Clock_50,
    input  logic              Resetn,
    input  logic              SRAM_ready,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_we_n,
    input  logic              p1_we_n,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic [DATA_W-1:0] SRAM_write_data,
    output logic              SRAM_we_n,
    input  logic [DATA_W-1:0] SRAM_read_data,
    output sram_arb_state_t   arb_state
);

    // Handshake: a requester holds req/addr/we_n/wdata until gnt; the access
    // is accepted on the rising edge that ends a cycle with req && gnt high.

    sram_arb_state_t state, state_next;
    logic            force_p1;
    logic            sel_p1;
    logic            cand_req;
    logic            cand_we_n;
    logic            other_read_pending;
    logic            late_block;
    logic            grant_ok;
    logic            accept;
    logic            last_wr_valid;
    arb_port_t       last_wr_port;

    always_comb begin
        cand_req           = p0_req | p1_req;
        sel_p1             = p1_req & (~p0_req | force_p1);
        cand_we_n          = sel_p1 ? p1_we_n : p0_we_n;
        other_read_pending = sel_p1 ? (p0_req & p0_we_n) : (p1_req & p1_we_n);
        // A read that shows up only after the other port's write was accepted
        // still needs its bubble; it is held here for that one cycle.
        late_block         = last_wr_valid && (last_wr_port != sel_p1) && cand_we_n;
        grant_ok           = Resetn && SRAM_ready && (state != S_ARB_TURN) && !late_block;
        p0_gnt             = grant_ok && p0_req && !sel_p1;
        p1_gnt             = grant_ok && sel_p1;
        accept             = p0_gnt | p1_gnt;
    end

    always_comb begin
        state_next = state;
        if (state == S_ARB_TURN) begin
            state_next = S_ARB_IDLE;
        end else if (accept) begin
            if (!cand_we_n && other_read_pending) begin
                state_next = S_ARB_TURN;
            end else begin
                state_next = sel_p1 ? S_ARB_P1 : S_ARB_P0;
            end
        end else if (!cand_req) begin
            state_next = S_ARB_IDLE;
        end
    end

    always_ff @(posedge Clock_50) begin
        if (!Resetn) begin
            state           <= S_ARB_IDLE;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            last_wr_valid   <= 1'b0;
            last_wr_port    <= PORT0;
        end else begin
            state         <= state_next;
            last_wr_valid <= accept && !cand_we_n;
            last_wr_port  <= sel_p1;
            if (accept) begin
                SRAM_address    <= sel_p1 ? p1_addr : p0_addr;
                SRAM_write_data <= sel_p1 ? p1_wdata : p0_wdata;
                SRAM_we_n       <= cand_we_n;
            end else begin
                SRAM_we_n <= 1'b1;
            end
        end
    end

`ifdef SRAM_ARB_STARVE_GUARD_EN
    logic [3:0] wait_cnt;

    always_ff @(posedge Clock_50) begin
        if (!Resetn || !p1_req || p1_gnt) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt < 4'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign force_p1 = (wait_cnt >= 4'(MAX_WAIT));
`else
    assign force_p1 = 1'b0;
`endif

    read_tag_pipe #(
        .DEPTH(READ_LATENCY + 1)
    ) u_tag_pipe (
        .clk    (Clock_50),
        .rst_n  (Resetn),
        .push   (accept && cand_we_n),
        .port   (sel_p1),
        .rvalid0(p0_rvalid),
        .rvalid1(p1_rvalid)
    );

    assign p0_rdata  = SRAM_read_data;
    assign p1_rdata  = SRAM_read_data;
    assign arb_state = state;

endmodule
